dc_restore: RTL and testbench

- Inverse of the DC-removal stage. Takes signed, zero-mean samples from the DSP chain, adds back a DC offset, saturates, and emits unsigned DAC codes.
- The offset soft-ramps from 0 to its target after reset, and on every retarget, so the DAC output never steps abruptly (no pop/glitch on the analog side).
- Sits between the processing chain and the DAC driver, in the dac_clk domain.

---
 rtl/dc_pkg.sv | 27 ++
 rtl/dc_offset_ramp.sv | 93 +++++++++
 rtl/dc_restore.sv | 65 ++++++
 tb/tb_dc_restore.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_pkg.sv
// Shared types and helpers for the DAC-side blocks: FSM state encoding,
// mid-scale code and the clip-to-unsigned saturation function.
package dc_pkg;

  typedef enum logic [1:0] {IDLE, RAMP, RUN} dc_state_t;

  localparam int unsigned CODE_W = 32;

  function automatic logic [CODE_W-1:0] mid_code(input int unsigned w);
    return CODE_W'(1) << (w - 1);
  endfunction

  // Returns {sat, code}: code clipped to [0, 2^w-1], sat set when clipping occurred.
  function automatic logic [CODE_W:0] sat_code(input logic signed [CODE_W+1:0] sum,
                                               input int unsigned w);
    logic [CODE_W-1:0] max_code;
    max_code = (w >= CODE_W) ? '1 : ((CODE_W'(1) << w) - CODE_W'(1));
    if (sum[CODE_W+1]) begin
      return {1'b1, {CODE_W{1'b0}}};
    end
    if (sum > $signed({2'b00, max_code})) begin
      return {1'b1, max_code};
    end
    return {1'b0, sum[CODE_W-1:0]};
  endfunction

endpackage

// File: rtl/dc_offset_ramp.sv
// DC offset soft-ramp: walks cur_offset toward target by at most RAMP_STEP
// every RAMP_DIV cycles, so retargets never step the DAC output abruptly.
module dc_offset_ramp
  import dc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned RAMP_STEP  = 16,
  parameter int unsigned RAMP_DIV   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_offset,
  input  logic                  i_offset_load,
  output logic [DATA_WIDTH-1:0] o_cur_offset,
  output logic                  o_ramp_done
);

  localparam int unsigned           DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [DATA_WIDTH-1:0] STEP     = DATA_WIDTH'(RAMP_STEP);
  localparam logic [DATA_WIDTH-1:0] MID      = DATA_WIDTH'(mid_code(DATA_WIDTH));

  dc_state_t             r_state, w_nxt_state;
  logic [DIV_W-1:0]      r_div, w_nxt_div;
  logic [DATA_WIDTH-1:0] r_target, w_nxt_target;
  logic [DATA_WIDTH-1:0] r_cur, w_nxt_cur;

  logic                  w_up;
  logic                  w_update;
  logic [DATA_WIDTH-1:0] w_dist;
  logic [DATA_WIDTH-1:0] w_step;
  logic [DATA_WIDTH-1:0] w_stepped;

  // Step is clamped to the remaining distance, so the offset never overshoots.
  assign w_up      = (r_target > r_cur);
  assign w_dist    = w_up ? (r_target - r_cur) : (r_cur - r_target);
  assign w_step    = (w_dist > STEP) ? STEP : w_dist;
  assign w_stepped = w_up ? (r_cur + w_step) : (r_cur - w_step);
  assign w_update  = (r_div == DIV_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_div    <= '0;
      r_target <= MID;
      r_cur    <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_div    <= w_nxt_div;
      r_target <= w_nxt_target;
      r_cur    <= w_nxt_cur;
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_div    = r_div;
    w_nxt_target = r_target;
    w_nxt_cur    = r_cur;
    case (r_state)
      IDLE: begin
        w_nxt_state = RAMP;
        w_nxt_div   = '0;
      end
      RAMP: begin
        w_nxt_div = w_update ? '0 : (r_div + DIV_W'(1));
        if (w_update) begin
          w_nxt_cur = w_stepped;
        end
        // A load on the arrival edge keeps the ramp going toward the new target.
        if (i_offset_load) begin
          w_nxt_target = i_offset;
        end else if (w_update && (w_stepped == r_target)) begin
          w_nxt_state = RUN;
        end
      end
      RUN: begin
        if (i_offset_load) begin
          w_nxt_target = i_offset;
          if (i_offset != r_cur) begin
            w_nxt_state = RAMP;
            w_nxt_div   = '0;
          end
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  assign o_cur_offset = r_cur;
  assign o_ramp_done  = (r_state == RUN);

endmodule

// File: rtl/dc_restore.sv
// Adds the soft-ramped DC offset back onto zero-mean samples and saturates the
// result into unsigned DAC codes through a 2-stage pipeline.
module dc_restore
  import dc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned RAMP_STEP  = 16,
  parameter int unsigned RAMP_DIV   = 4
) (
  input  logic                         dac_clk,
  input  logic                         stable,
  input  logic signed [DATA_WIDTH:0]   data_in,
  input  logic                         in_en,
  input  logic        [DATA_WIDTH-1:0] offset_in,
  input  logic                         offset_load,
  output logic        [DATA_WIDTH-1:0] data_out,
  output logic                         sat,
  output logic                         ramp_done
);

  logic        [DATA_WIDTH-1:0] w_cur_offset;
  logic signed [DATA_WIDTH+1:0] w_in_ext;
  logic signed [DATA_WIDTH+1:0] w_sum;
  logic signed [DATA_WIDTH+1:0] r_sum;
  logic signed [CODE_W+1:0]     w_sum_wide;
  logic        [CODE_W:0]       w_sat_res;
  logic                         w_unused_hi;
  logic        [DATA_WIDTH-1:0] r_data_out;
  logic                         r_sat;

  dc_offset_ramp #(
    .DATA_WIDTH (DATA_WIDTH),
    .RAMP_STEP  (RAMP_STEP),
    .RAMP_DIV   (RAMP_DIV)
  ) u_ramp (
    .i_clk         (dac_clk),
    .i_rst_n       (stable),
    .i_offset      (offset_in),
    .i_offset_load (offset_load),
    .o_cur_offset  (w_cur_offset),
    .o_ramp_done   (ramp_done)
  );

  assign w_in_ext   = in_en ? {data_in[DATA_WIDTH], data_in} : '0;
  assign w_sum      = w_in_ext + $signed({2'b00, w_cur_offset});
  assign w_sum_wide = {{(CODE_W - DATA_WIDTH){r_sum[DATA_WIDTH+1]}}, r_sum};
  assign w_sat_res  = sat_code(w_sum_wide, DATA_WIDTH);
  assign w_unused_hi = |w_sat_res[CODE_W-1:DATA_WIDTH];

  always_ff @(posedge dac_clk) begin
    if (!stable) begin
      r_sum      <= '0;
      r_data_out <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_sum      <= w_sum;
      r_data_out <= w_sat_res[DATA_WIDTH-1:0];
      r_sat      <= w_sat_res[CODE_W];
    end
  end

  assign data_out = r_data_out;
  assign sat      = r_sat;

endmodule

// File: tb/tb_dc_restore.sv
// Directed bench for dc_restore: reset, start-up ramp, add/saturate datapath,
// retargeting, ramp reversal and mid-stream reset.
module tb_dc_restore;

  localparam int DW = 12;

  logic                 dac_clk = 1'b0;
  logic                 stable = 1'b0;
  logic signed [DW:0]   data_in = '0;
  logic                 in_en = 1'b0;
  logic [DW-1:0]        offset_in = '0;
  logic                 offset_load = 1'b0;
  logic [DW-1:0]        data_out;
  logic                 sat;
  logic                 ramp_done;

  int checks = 0;
  int errors = 0;

  always #5 dac_clk = ~dac_clk;

  dc_restore #(
    .DATA_WIDTH (DW),
    .RAMP_STEP  (16),
    .RAMP_DIV   (4)
  ) dut (
    .dac_clk     (dac_clk),
    .stable      (stable),
    .data_in     (data_in),
    .in_en       (in_en),
    .offset_in   (offset_in),
    .offset_load (offset_load),
    .data_out    (data_out),
    .sat         (sat),
    .ramp_done   (ramp_done)
  );

  task automatic tick();
    @(posedge dac_clk);
    #1;
  endtask

  // Expected data_out n edges after reset release with in_en=0.
  function automatic int ramp_exp(input int n);
    int v;
    if (n < 3) return 0;
    v = 16 * ((n - 3) / 4);
    return (v > 2048) ? 2048 : v;
  endfunction

  task automatic test_reset();
    stable = 1'b0; in_en = 1'b0; offset_load = 1'b0; data_in = '0;
    tick(); tick();
    checks++;
    if (data_out !== 12'd0) begin
      errors++; $display("FAIL reset_data_out: got %0d want 0", data_out);
    end
    checks++;
    if (sat !== 1'b0) begin
      errors++; $display("FAIL reset_sat: got %b want 0", sat);
    end
    checks++;
    if (ramp_done !== 1'b0) begin
      errors++; $display("FAIL reset_ramp_done: got %b want 0", ramp_done);
    end
  endtask

  task automatic test_ramp_up();
    bit bad = 0;
    stable = 1'b1; in_en = 1'b0;
    for (int n = 1; n <= 530; n++) begin
      tick();
      if (!bad) begin
        checks++;
        if (data_out !== DW'(ramp_exp(n)) || sat !== 1'b0 || ramp_done !== 1'(n >= 513)) begin
          errors++; bad = 1;
          $display("FAIL ramp_up edge %0d: got out=%0d sat=%b done=%b want out=%0d sat=0 done=%b",
                   n, data_out, sat, ramp_done, ramp_exp(n), 1'(n >= 513));
        end
      end
    end
  endtask

  task automatic test_datapath();
    int vin [7] = '{100, -100, 0, 2047, -2048, 0, 0};
    int vexp[6] = '{2148, 1948, 2048, 4095, 0, 2048};
    in_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      data_in = (DW+1)'(vin[i]);
      tick();
      if (i >= 1) begin
        checks++;
        if (data_out !== DW'(vexp[i-1]) || sat !== 1'b0) begin
          errors++;
          $display("FAIL datapath[%0d]: got out=%0d sat=%b want out=%0d sat=0",
                   i - 1, data_out, sat, vexp[i-1]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    in_en = 1'b1; data_in = 13'sd2047;
    offset_in = 12'd3000; offset_load = 1'b1;
    tick();
    offset_load = 1'b0;
    checks++;
    if (ramp_done !== 1'b0) begin
      errors++; $display("FAIL sat_load_drop: ramp_done got %b want 0", ramp_done);
    end
    for (int i = 0; i < 1000 && ramp_done !== 1'b1; i++) tick();
    checks++;
    if (ramp_done !== 1'b1) begin
      errors++; $display("FAIL sat_wait_3000: ramp_done got %b want 1 (timeout)", ramp_done);
    end
    tick(); tick();
    checks++;
    if (data_out !== 12'd4095 || sat !== 1'b1) begin
      errors++; $display("FAIL sat_high: got out=%0d sat=%b want out=4095 sat=1", data_out, sat);
    end
    in_en = 1'b0;
    tick(); tick();
    checks++;
    if (data_out !== 12'd3000 || sat !== 1'b0) begin
      errors++; $display("FAIL offset_3000: got out=%0d sat=%b want out=3000 sat=0", data_out, sat);
    end
    in_en = 1'b1; data_in = -13'sd2048;
    offset_in = 12'd100; offset_load = 1'b1;
    tick();
    offset_load = 1'b0;
    for (int i = 0; i < 1000 && ramp_done !== 1'b1; i++) tick();
    checks++;
    if (ramp_done !== 1'b1) begin
      errors++; $display("FAIL sat_wait_100: ramp_done got %b want 1 (timeout)", ramp_done);
    end
    tick(); tick();
    checks++;
    if (data_out !== 12'd0 || sat !== 1'b1) begin
      errors++; $display("FAIL sat_low: got out=%0d sat=%b want out=0 sat=1", data_out, sat);
    end
  endtask

  task automatic test_small_retarget();
    in_en = 1'b0; data_in = '0;
    offset_in = 12'd2048; offset_load = 1'b1;
    tick();
    offset_load = 1'b0;
    for (int i = 0; i < 1000 && ramp_done !== 1'b1; i++) tick();
    tick(); tick();
    checks++;
    if (ramp_done !== 1'b1 || data_out !== 12'd2048) begin
      errors++; $display("FAIL back_to_2048: got out=%0d done=%b want out=2048 done=1", data_out, ramp_done);
    end
    offset_in = 12'd2050; offset_load = 1'b1;
    tick();
    offset_load = 1'b0;
    checks++;
    if (ramp_done !== 1'b0) begin
      errors++; $display("FAIL retarget_drop: ramp_done got %b want 0", ramp_done);
    end
    tick(); tick(); tick();
    checks++;
    if (ramp_done !== 1'b0 || data_out !== 12'd2048) begin
      errors++; $display("FAIL retarget_pre: got out=%0d done=%b want out=2048 done=0", data_out, ramp_done);
    end
    tick();
    checks++;
    if (ramp_done !== 1'b1) begin
      errors++; $display("FAIL retarget_done: ramp_done got %b want 1", ramp_done);
    end
    tick(); tick();
    checks++;
    if (data_out !== 12'd2050) begin
      errors++; $display("FAIL retarget_value: got out=%0d want 2050", data_out);
    end
    tick(); tick(); tick(); tick();
    checks++;
    if (data_out !== 12'd2050 || ramp_done !== 1'b1) begin
      errors++; $display("FAIL retarget_hold: got out=%0d done=%b want out=2050 done=1", data_out, ramp_done);
    end
  endtask

  task automatic test_reset_midstream();
    in_en = 1'b1; data_in = 13'sd500;
    tick(); tick();
    checks++;
    if (data_out !== 12'd2550 || sat !== 1'b0) begin
      errors++; $display("FAIL pre_reset_out: got out=%0d sat=%b want out=2550 sat=0", data_out, sat);
    end
    stable = 1'b0;
    tick();
    checks++;
    if (data_out !== 12'd0 || sat !== 1'b0 || ramp_done !== 1'b0) begin
      errors++;
      $display("FAIL midstream_reset: got out=%0d sat=%b done=%b want out=0 sat=0 done=0",
               data_out, sat, ramp_done);
    end
    stable = 1'b1; in_en = 1'b0; data_in = '0;
  endtask

  // Continues from the release performed at the end of test_reset_midstream.
  task automatic test_reversal();
    bit bad = 0;
    int n;
    int prev;
    for (n = 1; n <= 249; n++) begin
      tick();
      if (!bad) begin
        checks++;
        if (data_out !== DW'(ramp_exp(n))) begin
          errors++; bad = 1;
          $display("FAIL restart_ramp edge %0d: got %0d want %0d", n, data_out, ramp_exp(n));
        end
      end
    end
    n = 249;
    offset_in = 12'd500; offset_load = 1'b1;
    tick(); n++;
    offset_load = 1'b0;
    tick(); n++;
    checks++;
    if (data_out !== 12'd992) begin
      errors++; $display("FAIL reversal_peak: got %0d want 992", data_out);
    end
    tick(); tick(); tick(); tick(); n += 4;
    checks++;
    if (data_out !== 12'd976) begin
      errors++; $display("FAIL reversal_first_down: got %0d want 976", data_out);
    end
    prev = 976;
    bad = 0;
    while (ramp_done !== 1'b1 && n < 600) begin
      tick(); n++;
      if (!bad) begin
        checks++;
        if (int'(data_out) > prev || data_out < 12'd500) begin
          errors++; bad = 1;
          $display("FAIL reversal_monotonic edge %0d: got %0d want within [500,%0d]", n, data_out, prev);
        end
      end
      prev = int'(data_out);
    end
    checks++;
    if (ramp_done !== 1'b1 || n != 373) begin
      errors++; $display("FAIL reversal_settle_edge: got done=%b at edge %0d want done=1 at edge 373", ramp_done, n);
    end
    tick(); tick();
    checks++;
    if (data_out !== 12'd500 || sat !== 1'b0) begin
      errors++; $display("FAIL reversal_final: got out=%0d sat=%b want out=500 sat=0", data_out, sat);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_datapath();
    test_saturation();
    test_small_retarget();
    test_reset_midstream();
    test_reversal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
